// File: rtl/seven_segment_scanner_if.sv
// Display-side bundle for seven_segment_scanner: control/value inputs
// from the producer and the registered segment/anode pins back out.
interface seven_segment_scanner_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic                  off;
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic                  err;
  logic [6:0]            seg;
  logic [DIGITS-1:0]     anode;

  // Producer side: drives value/controls, observes the pins
  modport master (
    output start, off, load, value, err,
    input  seg, anode
  );

  // Scanner side: consumes value/controls, drives the pins
  modport slave (
    input  start, off, load, value, err,
    output seg, anode
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode seven-segment scanner.
// Shadows a packed hex value + error flag on load, then drives one digit
// per DWELL-cycle period; the first cycle of every period is a dead slot
// with all anodes off to avoid ghosting. Seg/anode are registered.
// Optional feature: define LZ_BLANK_EN for leading-zero suppression.
module seven_segment_scanner #(
  parameter int DIGITS = 4,
  parameter int DWELL  = 50000
) (
  input  logic                  clk,
  input  logic                  srst,
  seven_segment_scanner_if.slave bus
);

  localparam int CNT_W = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h7E;

  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [4*DIGITS-1:0] shadow_val_reg, shadow_val_next;
  logic                shadow_err_reg, shadow_err_next;
  logic [6:0]          seg_reg, seg_next;
  logic [DIGITS-1:0]   anode_reg, anode_next;

  logic [3:0]          nibbles [DIGITS];
  logic [3:0]          cur_nibble;
  logic                blank;
  logic                wrap;
  logic                lz_blank;

  // Split the shadow value into per-digit nibbles for indexed selection
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nibble
      assign nibbles[gi] = shadow_val_reg[4*gi +: 4];
    end
  endgenerate

`ifdef LZ_BLANK_EN
  // zero_from[k] is set when nibbles k..DIGITS-1 are all zero
  logic [DIGITS-1:0] zero_from;
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_zero
      assign zero_from[gi] = (shadow_val_reg[4*DIGITS-1:4*gi] == '0);
    end
  endgenerate
  // Digit 0 is never suppressed so a zero value still shows "0"
  assign lz_blank = zero_from[idx_reg] && (idx_reg != '0);
`else
  assign lz_blank = 1'b0;
`endif

  assign cur_nibble = nibbles[idx_reg];
  assign blank      = bus.off | ~bus.start;
  assign wrap       = (cnt_reg == CNT_MAX);

  // Active-low abcdefg decode of one hex nibble
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h04;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      default: s = 7'h38;
    endcase
    return s;
  endfunction

  // Dwell counter, digit index and shadow capture
  always_comb begin
    cnt_next        = wrap ? '0 : cnt_reg + 1'b1;
    idx_next        = idx_reg;
    shadow_val_next = shadow_val_reg;
    shadow_err_next = shadow_err_reg;
    if (wrap) begin
      idx_next = (idx_reg == IDX_MAX) ? '0 : idx_reg + 1'b1;
    end
    if (bus.load) begin
      shadow_val_next = bus.value;
      shadow_err_next = bus.err;
    end
  end

  // Pin values for the next cycle: blank > dead slot > error > decode
  always_comb begin
    seg_next   = SEG_BLANK;
    anode_next = '1;
    if (!blank && (cnt_reg != '0)) begin
      anode_next = ~(DIGITS'(1) << idx_reg);
      if (shadow_err_reg) begin
        seg_next = SEG_DASH;
      end else if (lz_blank) begin
        seg_next = SEG_BLANK;
      end else begin
        seg_next = hex_decode(cur_nibble);
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg        <= '0;
      idx_reg        <= '0;
      shadow_val_reg <= '0;
      shadow_err_reg <= 1'b0;
      seg_reg        <= SEG_BLANK;
      anode_reg      <= '1;
    end else begin
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      shadow_val_reg <= shadow_val_next;
      shadow_err_reg <= shadow_err_next;
      seg_reg        <= seg_next;
      anode_reg      <= anode_next;
    end
  end

  assign bus.seg   = seg_reg;
  assign bus.anode = anode_reg;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner with DIGITS=4, DWELL=4.
// Edge k (k>=1) is the k-th rising edge after reset release; the pins
// sampled after it reflect counter position cnt=(k-1)%4, idx=((k-1)/4)%4.
module tb_seven_segment_scanner;

  localparam int DIGITS = 4;
  localparam int DWELL  = 4;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] anode;
  } exp_t;

  localparam exp_t BLANK = '{seg: 7'h7F, anode: 4'hF};
  localparam logic [6:0] DEC [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                      7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
  // Hand-decoded expectations for value 16'h12AF, digit 0..3
  localparam logic [6:0] SCAN_SEG [4] = '{7'h38, 7'h08, 7'h12, 7'h4F};
  localparam logic [3:0] SCAN_AN  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  logic clk = 1'b0;
  logic srst;
  exp_t sb_q [$];
  exp_t want;
  int   tests_run = 0;
  int   tests_failed = 0;

  seven_segment_scanner_if #(.DIGITS(DIGITS)) bus_if ();

  seven_segment_scanner #(.DIGITS(DIGITS), .DWELL(DWELL)) dut (
    .clk  (clk),
    .srst (srst),
    .bus  (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected unblanked pins at edge k for a given shadow value/error
  function automatic exp_t pos_exp(int k, logic [15:0] v, logic e);
    exp_t r;
    int cnt;
    int idx;
    logic [15:0] upper;
    cnt = (k - 1) % DWELL;
    idx = ((k - 1) / DWELL) % DIGITS;
    if (cnt == 0) return BLANK;
    r.anode = ~(4'b0001 << idx);
    upper   = v >> (4 * idx);
    if (e) r.seg = 7'h7E;
`ifdef LZ_BLANK_EN
    else if (idx > 0 && upper == 16'h0) r.seg = 7'h7F;
`endif
    else r.seg = DEC[upper[3:0]];
    return r;
  endfunction

  task automatic apply_reset(int n);
    srst = 1'b1;
    bus_if.load = 1'b0;
    bus_if.off = 1'b0;
    bus_if.start = 1'b1;
    bus_if.err = 1'b0;
    bus_if.value = 16'h0;
    repeat (n) tick();
    srst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t got;
    srst = 1'b1;
    bus_if.start = 1'b1;
    bus_if.off = 1'b0;
    bus_if.load = 1'b0;
    bus_if.err = 1'b0;
    bus_if.value = 16'h0;
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back(BLANK);
      tick();
      got = sb_q.pop_front();
      tests_run++;
      if ({bus_if.seg, bus_if.anode} !== got) begin
        tests_failed++;
        $display("FAIL reset_hold cyc=%0d seg=%h anode=%h want seg=%h anode=%h", k, bus_if.seg, bus_if.anode, got.seg, got.anode);
      end else $display("[TB] reset_hold cyc=%0d seg=%h anode=%h", k, bus_if.seg, bus_if.anode);
    end
    srst = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      sb_q.push_back(pos_exp(k, 16'h0, 1'b0));
      tick();
      got = sb_q.pop_front();
      tests_run++;
      if ({bus_if.seg, bus_if.anode} !== got) begin
        tests_failed++;
        $display("FAIL reset_release k=%0d seg=%h anode=%h want seg=%h anode=%h", k, bus_if.seg, bus_if.anode, got.seg, got.anode);
      end else $display("[TB] reset_release k=%0d seg=%h anode=%h", k, bus_if.seg, bus_if.anode);
    end
  endtask

  task automatic test_scan();
    exp_t got;
    apply_reset(2);
    for (int k = 1; k <= 20; k++) begin
      int cnt = (k - 1) % 4;
      int idx = ((k - 1) / 4) % 4;
      bus_if.load  = (k == 1);
      bus_if.value = (k == 1) ? 16'h12AF : 16'hDEAD;
      if (cnt == 0) sb_q.push_back(BLANK);
      else sb_q.push_back('{seg: SCAN_SEG[idx], anode: SCAN_AN[idx]});
      tick();
      got = sb_q.pop_front();
      tests_run++;
      if ({bus_if.seg, bus_if.anode} !== got) begin
        tests_failed++;
        $display("FAIL scan k=%0d seg=%h anode=%h want seg=%h anode=%h", k, bus_if.seg, bus_if.anode, got.seg, got.anode);
      end else $display("[TB] scan k=%0d seg=%h anode=%h", k, bus_if.seg, bus_if.anode);
    end
    bus_if.load = 1'b0;
  endtask

  task automatic test_error();
    exp_t got;
    apply_reset(2);
    for (int k = 1; k <= 16; k++) begin
      bus_if.load  = (k == 1);
      bus_if.err   = (k == 1);
      bus_if.value = 16'h12AF;
      sb_q.push_back(pos_exp(k, 16'h12AF, 1'b1));
      tick();
      got = sb_q.pop_front();
      tests_run++;
      if ({bus_if.seg, bus_if.anode} !== got) begin
        tests_failed++;
        $display("FAIL error_dash k=%0d seg=%h anode=%h want seg=%h anode=%h", k, bus_if.seg, bus_if.anode, got.seg, got.anode);
      end else $display("[TB] error_dash k=%0d seg=%h anode=%h", k, bus_if.seg, bus_if.anode);
    end
    bus_if.load = 1'b0;
    bus_if.err = 1'b0;
  endtask

  task automatic test_zero();
    exp_t got;
    apply_reset(2);
    // Shadow is made non-zero first so that loading zero is observable
    for (int k = 1; k <= 20; k++) begin
      bus_if.load  = (k == 1) || (k == 4);
      bus_if.err   = 1'b0;
      bus_if.value = (k == 1) ? 16'h8888 : 16'h0000;
      if (k <= 4) sb_q.push_back(pos_exp(k, 16'h8888, 1'b0));
      else sb_q.push_back(pos_exp(k, 16'h0000, 1'b0));
      tick();
      got = sb_q.pop_front();
      tests_run++;
      if ({bus_if.seg, bus_if.anode} !== got) begin
        tests_failed++;
        $display("FAIL zero_value k=%0d seg=%h anode=%h want seg=%h anode=%h", k, bus_if.seg, bus_if.anode, got.seg, got.anode);
      end else $display("[TB] zero_value k=%0d seg=%h anode=%h", k, bus_if.seg, bus_if.anode);
    end
    bus_if.load = 1'b0;
  endtask

  task automatic test_blank();
    exp_t got;
    apply_reset(2);
    for (int k = 1; k <= 14; k++) begin
      bus_if.load  = (k == 1) || (k == 8);
      bus_if.value = (k == 1) ? 16'h12AF : 16'h3456;
      bus_if.off   = (k == 7) || (k == 8);
      bus_if.start = (k != 9);
      if (k >= 7 && k <= 9) sb_q.push_back(BLANK);
      else if (k < 7) sb_q.push_back(pos_exp(k, 16'h12AF, 1'b0));
      else sb_q.push_back(pos_exp(k, 16'h3456, 1'b0));
      tick();
      got = sb_q.pop_front();
      tests_run++;
      if ({bus_if.seg, bus_if.anode} !== got) begin
        tests_failed++;
        $display("FAIL blank k=%0d seg=%h anode=%h want seg=%h anode=%h", k, bus_if.seg, bus_if.anode, got.seg, got.anode);
      end else $display("[TB] blank k=%0d seg=%h anode=%h", k, bus_if.seg, bus_if.anode);
    end
    bus_if.load = 1'b0;
    bus_if.off = 1'b0;
    bus_if.start = 1'b1;
  endtask

  task automatic test_load_wrap();
    exp_t got;
    apply_reset(2);
    // Edge 16 is the 3->0 digit wrap; the load lands on that same edge
    for (int k = 1; k <= 19; k++) begin
      bus_if.load  = (k == 1) || (k == 16);
      bus_if.value = (k == 1) ? 16'h12AF : 16'h0005;
      if (k <= 16) sb_q.push_back(pos_exp(k, 16'h12AF, 1'b0));
      else sb_q.push_back(pos_exp(k, 16'h0005, 1'b0));
      tick();
      got = sb_q.pop_front();
      tests_run++;
      if ({bus_if.seg, bus_if.anode} !== got) begin
        tests_failed++;
        $display("FAIL load_wrap k=%0d seg=%h anode=%h want seg=%h anode=%h", k, bus_if.seg, bus_if.anode, got.seg, got.anode);
      end else $display("[TB] load_wrap k=%0d seg=%h anode=%h", k, bus_if.seg, bus_if.anode);
    end
    bus_if.load = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t got;
    apply_reset(2);
    // After edge 10 the scanner sits at idx=2, cnt=2; reset hits edge 11
    for (int k = 1; k <= 14; k++) begin
      bus_if.load  = (k == 1);
      bus_if.value = 16'h12AF;
      srst = (k == 11);
      if (k <= 10) sb_q.push_back(pos_exp(k, 16'h12AF, 1'b0));
      else if (k == 11) sb_q.push_back(BLANK);
      else sb_q.push_back(pos_exp(k - 11, 16'h0000, 1'b0));
      tick();
      got = sb_q.pop_front();
      tests_run++;
      if ({bus_if.seg, bus_if.anode} !== got) begin
        tests_failed++;
        $display("FAIL reset_mid k=%0d seg=%h anode=%h want seg=%h anode=%h", k, bus_if.seg, bus_if.anode, got.seg, got.anode);
      end else $display("[TB] reset_mid k=%0d seg=%h anode=%h", k, bus_if.seg, bus_if.anode);
    end
    srst = 1'b0;
    bus_if.load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_error();
    test_zero();
    test_blank();
    test_load_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
